seg_hex_disp: RTL and testbench

SEG_HEX_DISP -- requirements
Module: seg_hex_disp

---
 rtl/seg_hex_disp.sv | 140 ++++++++++++++
 tb/tb_seg_hex_disp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_hex_disp.sv
// seg_hex_disp -- multi-digit seven-segment hex display driver.
//
// Captures a packed hex value plus per-digit decimal-point and blink masks
// on a write strobe and drives registered, active-low segment patterns.
// Until the first write after reset the display stays dark. Leading-zero
// blanking is controlled live by lzb_en, and a free-running divider
// produces the blink phase for digits whose blink bit is set.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   wr_en     : load strobe for wr_data, dp_in, blink_en
//   wr_data   : 4*DIGITS bits, nibble i drives digit i (digit 0 = LSB)
//   dp_in     : DIGITS bits, decimal point per digit, 1 = lit
//   blink_en  : DIGITS bits, blink enable per digit
//   lzb_en    : leading-zero blanking enable, used live (not latched)
//   seg_out   : 8*DIGITS bits, registered, active-low, digit i at
//               [8i+7:8i] ordered {a,b,c,d,e,f,g,dp}

module seg_hex_disp #(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  lzb_en,
    output logic [8*DIGITS-1:0]   seg_out
);

    localparam int CW = $clog2(BLINK_DIV);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blink_q;
    logic [CW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [8*DIGITS-1:0] seg_next;

    // Active-low {a..g} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Next segment image, built from the registered state so a write or a
    // blink toggle at one edge shows up together at the following edge.
    logic       zero_run;
    logic [3:0] nib;
    logic [7:0] digit;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        seg_next = '1;
        zero_run = lzb_en;
        nib      = '0;
        digit    = '1;
        // Walk from the most significant digit down; zero_run stays high
        // only while every nibble seen so far is zero. Digit 0 is exempt so
        // an all-zero value still shows a single "0".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = data_q[4*i +: 4];
            if (i != 0) begin
                zero_run = zero_run && (nib == 4'h0);
            end else begin
                zero_run = 1'b0;
            end
            // Leading-zero blanking clears a..g only; dp is kept.
            digit = {(zero_run ? 7'h7F : hex_to_seg(nib)), ~dp_q[i]};
            // Blink blanking takes the whole digit, dp included.
            if (blink_phase && blink_q[i]) begin
                digit = 8'hFF;
            end
            seg_next[8*i +: 8] = digit;
        end
        if (state == BLANK) begin
            seg_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            state       <= BLANK;
            data_q      <= '0;
            dp_q        <= '0;
            blink_q     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_out     <= '1;
        end else begin
            // Blink divider runs regardless of writes.
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end

            if (wr_en) begin
                data_q  <= wr_data;
                dp_q    <= dp_in;
                blink_q <= blink_en;
                state   <= SHOW;
            end

            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_hex_disp.sv
// tb_seg_hex_disp -- directed self-checking bench for seg_hex_disp with
// DIGITS=8 and a short blink divider (BLINK_DIV=4).
//
// Inputs are changed 1 ns after a rising edge and outputs are sampled at
// the same point, so every value is stable when looked at.

module tb_seg_hex_disp;

    localparam int DIGITS    = 8;
    localparam int BLINK_DIV = 4;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [4*DIGITS-1:0] wr_data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blink_en;
    logic                lzb_en;
    logic [8*DIGITS-1:0] seg_out;

    int n_vec;
    int n_mis;

    seg_hex_disp #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .dp_in    (dp_in),
        .blink_en (blink_en),
        .lzb_en   (lzb_en),
        .seg_out  (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dig(input int i);
        return seg_out[8*i +: 8];
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        step();
        rst   = 1'b0;
    endtask

    // Write at the next edge, leave the strobe low afterwards; the new
    // image is visible after one more edge.
    task automatic do_write(input logic [31:0] d, input logic [7:0] dp,
                            input logic [7:0] bl);
        wr_en    = 1'b1;
        wr_data  = d;
        dp_in    = dp;
        blink_en = bl;
        step();
        wr_en    = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            n_vec++;
            if (seg_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                n_mis++;
                $display("FAIL reset_idle cycle %0d: got %h want ffffffffffffffff", c, seg_out);
            end
            step();
        end
    endtask

    task automatic test_decode();
        logic [7:0] exp_lo [8];
        logic [7:0] exp_hi [8];
        exp_lo = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
        exp_hi = '{8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        lzb_en = 1'b0;
        // Spot check: digit0 shows 7, digit7 shows 0.
        do_write(32'h0123_4567, 8'h00, 8'h00);
        n_vec++;
        if (dig(0) !== 8'b00011111 || dig(7) !== 8'b00000011) begin
            n_mis++;
            $display("FAIL decode_spot: d0=%b d7=%b want 00011111 00000011", dig(0), dig(7));
        end
        do_write(32'h7654_3210, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (dig(i) !== exp_lo[i]) begin
                n_mis++;
                $display("FAIL decode_%0h: got %h want %h", i, dig(i), exp_lo[i]);
            end
        end
        do_write(32'hFEDC_BA98, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (dig(i) !== exp_hi[i]) begin
                n_mis++;
                $display("FAIL decode_%0h: got %h want %h", i + 8, dig(i), exp_hi[i]);
            end
        end
    endtask

    task automatic test_lzb();
        logic [63:0] exp;
        // Leading zeros blank a..g but keep the lit dp on digit 7.
        lzb_en = 1'b1;
        do_write(32'h0000_00A0, 8'h80, 8'h00);
        exp = {8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h03};
        n_vec++;
        if (seg_out !== exp) begin
            n_mis++;
            $display("FAIL lzb_a0: got %h want %h", seg_out, exp);
        end
        // lzb_en is live: dropping it re-shows the zeros with no write.
        lzb_en = 1'b0;
        step();
        exp = {8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h11, 8'h03};
        n_vec++;
        if (seg_out !== exp) begin
            n_mis++;
            $display("FAIL lzb_live_off: got %h want %h", seg_out, exp);
        end
        // All zero: only digit 0 remains.
        lzb_en = 1'b1;
        do_write(32'h0000_0000, 8'h00, 8'h00);
        exp = {{7{8'hFF}}, 8'h03};
        n_vec++;
        if (seg_out !== exp) begin
            n_mis++;
            $display("FAIL lzb_all_zero: got %h want %h", seg_out, exp);
        end
        // Blanking stops at the first nonzero nibble; inner zeros stay.
        do_write(32'h0010_2000, 8'h00, 8'h00);
        exp = {8'hFF, 8'hFF, 8'h9F, 8'h03, 8'h25, 8'h03, 8'h03, 8'h03};
        n_vec++;
        if (seg_out !== exp) begin
            n_mis++;
            $display("FAIL lzb_inner_zero: got %h want %h", seg_out, exp);
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_dp();
        logic [63:0] exp;
        do_write(32'h8888_8888, 8'hA5, 8'h00);
        // dp bit active-low: lit digits 7,5,2,0 end in 0.
        exp = {8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
        n_vec++;
        if (seg_out !== exp) begin
            n_mis++;
            $display("FAIL dp_pattern: got %h want %h", seg_out, exp);
        end
    endtask

    task automatic test_back_to_back();
        wr_en    = 1'b1;
        wr_data  = 32'h0000_0001;
        dp_in    = 8'h00;
        blink_en = 8'h00;
        step();
        wr_data  = 32'h0000_0002;
        step();
        wr_en    = 1'b0;
        n_vec++;
        if (dig(0) !== 8'h9F) begin
            n_mis++;
            $display("FAIL b2b_first: got %h want 9f", dig(0));
        end
        step();
        n_vec++;
        if (dig(0) !== 8'h25) begin
            n_mis++;
            $display("FAIL b2b_second: got %h want 25", dig(0));
        end
    endtask

    task automatic test_rst_wr();
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 32'h1234_5678;
        dp_in    = 8'hFF;
        blink_en = 8'h00;
        step();
        rst      = 1'b0;
        wr_en    = 1'b0;
        n_vec++;
        if (seg_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_mis++;
            $display("FAIL rst_wr_same: got %h want all ff", seg_out);
        end
        // Write discarded: still dark two edges later.
        step();
        step();
        n_vec++;
        if (seg_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_mis++;
            $display("FAIL rst_wr_discard: got %h want all ff", seg_out);
        end
    endtask

    // Offsets from the reset edge at which digit 0 must be dark, for a
    // write issued in the first cycle after reset (phase toggles every 4).
    function automatic bit blank_at(input int off);
        return ((off - 1) / BLINK_DIV) % 2 == 1;
    endfunction

    task automatic test_blink();
        logic [7:0] want;
        lzb_en = 1'b0;
        do_reset();
        wr_en    = 1'b1;
        wr_data  = 32'h0000_0000;
        dp_in    = 8'h00;
        blink_en = 8'h01;
        step();                         // offset 1: write captured
        wr_en    = 1'b0;
        for (int off = 2; off <= 16; off++) begin
            step();
            want = blank_at(off) ? 8'hFF : 8'h03;
            n_vec++;
            if (dig(0) !== want || seg_out[63:8] !== {7{8'h03}}) begin
                n_mis++;
                $display("FAIL blink_off%0d: got %h want %h rest=%h", off, dig(0), want, seg_out[63:8]);
            end
        end
    endtask

    task automatic test_coincide();
        // Phase toggles at offset 4; a write at that same edge and the
        // toggle must both land in the offset-5 image.
        do_reset();
        wr_en    = 1'b1;
        wr_data  = 32'h0000_0000;
        dp_in    = 8'h00;
        blink_en = 8'h01;
        step();                         // offset 1
        wr_en    = 1'b0;
        step();                         // offset 2
        step();                         // offset 3
        wr_en    = 1'b1;
        wr_data  = 32'h0000_0050;
        step();                         // offset 4: write + toggle
        wr_en    = 1'b0;
        n_vec++;
        if (dig(0) !== 8'h03 || dig(1) !== 8'h03) begin
            n_mis++;
            $display("FAIL coincide_before: d0=%h d1=%h want 03 03", dig(0), dig(1));
        end
        step();                         // offset 5
        n_vec++;
        if (dig(0) !== 8'hFF || dig(1) !== 8'h49) begin
            n_mis++;
            $display("FAIL coincide_after: d0=%h d1=%h want ff 49", dig(0), dig(1));
        end
    endtask

    task automatic test_rst_blink();
        logic [7:0] want;
        do_reset();
        wr_en    = 1'b1;
        wr_data  = 32'h0000_0000;
        dp_in    = 8'h00;
        blink_en = 8'h01;
        step();
        wr_en    = 1'b0;
        for (int off = 2; off <= 6; off++) step();
        n_vec++;
        if (dig(0) !== 8'hFF) begin
            n_mis++;
            $display("FAIL rst_blink_pre: got %h want ff", dig(0));
        end
        // Reset mid-blank; the phase must restart at 0.
        do_reset();
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        for (int off = 2; off <= 9; off++) begin
            step();
            want = blank_at(off) ? 8'hFF : 8'h03;
            n_vec++;
            if (dig(0) !== want) begin
                n_mis++;
                $display("FAIL rst_blink_off%0d: got %h want %h", off, dig(0), want);
            end
        end
    endtask

    initial begin
        n_vec    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        dp_in    = '0;
        blink_en = '0;
        lzb_en   = 1'b0;
        test_reset();
        test_decode();
        test_lzb();
        test_dp();
        test_back_to_back();
        test_rst_wr();
        test_blink();
        test_coincide();
        test_rst_blink();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
